// File: rtl/rom_load_ctrl.sv
// rom_load_ctrl: sequences the ROM download from the hps_io ioctl stream into
// the Sprint 1 download port. It also owns the core's active-low reset.
// Bytes below EXPECT_BYTES are forwarded as one-cycle writes, tagged with a
// ROM region, and summed into the checksum. Bytes at or beyond EXPECT_BYTES
// are dropped and mark the image as overflowed. When the download ends, the
// image is judged valid only if the accepted count is exact and no overflow
// occurred.

module rom_load_ctrl #(
    parameter logic [19:0] EXPECT_BYTES = 20'd20480,
    parameter logic [16:0] GFX_BASE     = 17'h04000,
    parameter logic [16:0] SND_BASE     = 17'h04800,
    parameter logic [15:0] HOLD_CYCLES  = 16'd1024,
    parameter bit          REQUIRE_LOAD = 1'b1
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        rst_req,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [16:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic [1:0]  dn_region,
    output logic        core_reset_n,
    output logic        rom_ok,
    output logic        load_err,
    output logic [7:0]  checksum
);

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [15:0] HOLD_RELOAD = HOLD_CYCLES - 16'd1;

    // Sequencer state
    state_t      state_q,        state_d;
    logic [15:0] hold_cnt_q,     hold_cnt_d;
    logic [19:0] byte_cnt_q,     byte_cnt_d;
    logic [7:0]  checksum_q,     checksum_d;
    logic        ovf_q,          ovf_d;
    logic        rom_ok_q,       rom_ok_d;
    logic        load_err_q,     load_err_d;
    logic        core_reset_n_q, core_reset_n_d;

    // Registered download port
    logic [16:0] dn_addr_q;
    logic [7:0]  dn_data_q;
    logic        dn_wr_q;
    logic [1:0]  dn_region_q;

    // Byte decode
    logic        addr_in_range;
    logic        accept;
    logic        overflow_byte;
    logic [1:0]  region_dec;
    logic [19:0] byte_cnt_inc;

    // Classify the incoming byte: in range or overflow, and which ROM region.
    always_comb begin
        addr_in_range = (ioctl_addr < {5'd0, EXPECT_BYTES});
        accept        = (state_q == ST_LOAD) && ioctl_wr && addr_in_range;
        overflow_byte = (state_q == ST_LOAD) && ioctl_wr && !addr_in_range;

        if (ioctl_addr < {8'd0, GFX_BASE}) begin
            region_dec = 2'd0;
        end else if (ioctl_addr < {8'd0, SND_BASE}) begin
            region_dec = 2'd1;
        end else begin
            region_dec = 2'd2;
        end

        byte_cnt_inc = (byte_cnt_q == '1) ? byte_cnt_q : byte_cnt_q + 20'd1;
    end

    // Next-state logic for the HOLD/LOAD/RUN sequencer and its bookkeeping.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        byte_cnt_d = byte_cnt_q;
        checksum_d = checksum_q;
        ovf_d      = ovf_q;
        rom_ok_d   = rom_ok_q;
        load_err_d = load_err_q;

        case (state_q)
            ST_HOLD: begin
                if (ioctl_download) begin
                    state_d    = ST_LOAD;
                    byte_cnt_d = '0;
                    checksum_d = '0;
                    ovf_d      = 1'b0;
                    load_err_d = 1'b0;
                    rom_ok_d   = 1'b0;
                end else if (rst_req) begin
                    hold_cnt_d = HOLD_RELOAD;
                end else if (hold_cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q - 16'd1;
                end
            end

            ST_LOAD: begin
                if (accept) begin
                    byte_cnt_d = byte_cnt_inc;
                    checksum_d = checksum_q + ioctl_dout;
                end
                if (overflow_byte) begin
                    ovf_d = 1'b1;
                end
                // A strobe in the same cycle as the download's end is counted
                // first, so validity is judged on the updated count and flag.
                if (!ioctl_download) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = HOLD_RELOAD;
                    if ((byte_cnt_d == EXPECT_BYTES) && !ovf_d) begin
                        rom_ok_d   = 1'b1;
                        load_err_d = 1'b0;
                    end else begin
                        rom_ok_d   = 1'b0;
                        load_err_d = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                // A new download takes priority over a reset request because
                // LOAD keeps the core in reset anyway and ends in HOLD.
                if (ioctl_download) begin
                    state_d    = ST_LOAD;
                    byte_cnt_d = '0;
                    checksum_d = '0;
                    ovf_d      = 1'b0;
                    load_err_d = 1'b0;
                    rom_ok_d   = 1'b0;
                end else if (rst_req) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = HOLD_RELOAD;
                end
            end

            default: begin
                state_d    = ST_HOLD;
                hold_cnt_d = HOLD_RELOAD;
            end
        endcase

        // The core reset is registered from the next state so it is glitch-free
        // and changes on the same edge as the state register.
        core_reset_n_d = (state_d == ST_RUN) && (rom_ok_d || !REQUIRE_LOAD);
    end

    // Sequencer state register.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q        <= ST_HOLD;
            hold_cnt_q     <= HOLD_RELOAD;
            byte_cnt_q     <= '0;
            checksum_q     <= '0;
            ovf_q          <= 1'b0;
            rom_ok_q       <= 1'b0;
            load_err_q     <= 1'b0;
            core_reset_n_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            hold_cnt_q     <= hold_cnt_d;
            byte_cnt_q     <= byte_cnt_d;
            checksum_q     <= checksum_d;
            ovf_q          <= ovf_d;
            rom_ok_q       <= rom_ok_d;
            load_err_q     <= load_err_d;
            core_reset_n_q <= core_reset_n_d;
        end
    end

    // Download port register: one strobe per accepted byte; address, data and
    // region hold their last value between strobes.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dn_wr_q     <= 1'b0;
            dn_addr_q   <= '0;
            dn_data_q   <= '0;
            dn_region_q <= '0;
        end else begin
            dn_wr_q <= accept;
            if (accept) begin
                dn_addr_q   <= ioctl_addr[16:0];
                dn_data_q   <= ioctl_dout;
                dn_region_q <= region_dec;
            end
        end
    end

    assign dn_addr      = dn_addr_q;
    assign dn_data      = dn_data_q;
    assign dn_wr        = dn_wr_q;
    assign dn_region    = dn_region_q;
    assign core_reset_n = core_reset_n_q;
    assign rom_ok       = rom_ok_q;
    assign load_err     = load_err_q;
    assign checksum     = checksum_q;

endmodule
